param_add_acc: RTL and testbench
================================

Name: param_add_acc

Overview:
- Parametrised registered adder/accumulator. Next generation of the team's combinational x+y adder task.
- Adds two WIDTH-bit operands per accepted transaction.
- Two modes:
  - plain sum (mode 0): z = x+y.
  - running accumulate (mode 1): acc += x+y.
- Valid/ready handshakes on both sides; stall-safe output register. Used as a stimulus/checker datapath in block-level benches and as a small arithmetic unit in RTL.

Parameters:
- WIDTH, 3, operand width in bits.
- ACC_W, 8, accumulator/result width in bits. Must be ≥ WIDTH+1.
- CNT_W, 8, width of the accepted-transaction counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- mode  in  1  0 = sum, 1 = accumulate; sampled with operands
- clr  in  1  clear accumulator, overflow flag and counter
- x  in  WIDTH  operand A, unsigned
- y  in  WIDTH  operand B, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- z  out  ACC_W  result: zero-extended x+y (mode 0) or new acc value (mode 1)
- ovf  out  1  sticky accumulate overflow flag
- txn_cnt  out  CNT_W  number of accepted transactions, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, z=0, acc=0, ovf=0, txn_cnt=0. in_ready=1 once rst is released. Reset mid-transaction discards the held result immediately.
- Accept condition: accept = in_valid & in_ready.
- in_ready = (state==IDLE) | out_ready. This gives full throughput with no bubble when out_ready stays high.
- States:
  - IDLE: out_valid=0. On accept → FULL.
  - FULL: out_valid=1, z held stable.
    - out_ready & accept → stay FULL, load the new result.
    - out_ready & !accept → IDLE.
    - !out_ready → hold; z, out_valid and ovf are unchanged.
- Latency: result appears on z one clock after accept.
- Sum arithmetic: s = x+y, computed in WIDTH+1 bits, never truncated.
- Mode 0: z = zero-extend(s). acc is unchanged.
- Mode 1: nxt = acc+s, computed in ACC_W+1 bits.
  - acc and z ← nxt[ACC_W-1:0].
  - If nxt[ACC_W]=1, ovf ← 1. ovf stays 1 until clr or rst.
- txn_cnt increments by 1 on every accept (either mode) and wraps from 2^CNT_W-1 to 0.
- clr without accept: acc=0, ovf=0, txn_cnt=0. No output is produced and out_valid/z are unchanged.
- clr with accept (simultaneous): clear is applied first, then the transaction.
  - Mode 1: acc=z=s.
  - Mode 0: acc=0, z=s.
  - In both cases ovf=0 and txn_cnt=1.
- clr is ignored while rst=1.

Optional Feature:
- Macro: PARAM_ADD_ACC_SAT_EN.
- Defined: mode-1 overflow saturates. acc and z ← 2^ACC_W-1, ovf ← 1, and acc stays saturated on later adds until clr.
- Undefined: mode-1 overflow wraps modulo 2^ACC_W, ovf ← 1.
- Mode 0 is unaffected in both builds.

Test Plan:
- Sum mode (WIDTH=3, ACC_W=8, out_ready=1): mode=0, send (5,5), (6,6), (7,7), (4,4) back-to-back → z=10,12,14,8 on consecutive cycles, each one cycle after accept; txn_cnt=4; acc=0.
- Accumulate wrap (SAT_EN undefined): mode=1, send (7,7) ×19 → z=14,28,…,252; 19th gives z=10 with ovf=1. A further (1,2) gives z=13, ovf still 1.
- Saturate (SAT_EN defined): same stimulus → 19th gives z=255, ovf=1. A further (1,2) gives z=255.
- Backpressure: send (6,3) with out_ready=0 → out_valid=1, z=9, in_ready=0 for 5 cycles while in_valid stays high with (6,7), and z holds 9. Raise out_ready → 9 consumed and 13 loaded in the same cycle.
- Simultaneous clr: acc=20, ovf=1, then clr=1 with accept of mode 1 (3,4) → z=7, acc=7, ovf=0, txn_cnt=1. Separately, clr alone → acc=0, out_valid unchanged.
- Reset mid-operation: rst asserted asynchronously between edges while in FULL with z=14 → out_valid=0, z=0, txn_cnt=0 immediately. After release, (1,2) gives z=3.

Source files
------------

// File: rtl/param_add_acc_if.sv
// Handshake/data bundle for param_add_acc.
// master: operand producer + result consumer; slave: the adder.
interface param_add_acc_if #(
  parameter int WIDTH = 3,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             mode;
  logic             clr;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] z;
  logic             ovf;
  logic [CNT_W-1:0] txn_cnt;

  modport master (
    output in_valid, mode, clr, x, y, out_ready,
    input  in_ready, out_valid, z, ovf, txn_cnt
  );

  modport slave (
    input  in_valid, mode, clr, x, y, out_ready,
    output in_ready, out_valid, z, ovf, txn_cnt
  );
endinterface

// File: rtl/param_add_acc.sv
// Registered adder/accumulator: z = x+y (mode 0) or acc += x+y (mode 1).
// Ports: clk, rst (async high), bus (slave): in_valid/in_ready, mode, clr,
//   x, y, out_valid/out_ready, z, ovf (sticky), txn_cnt.
// Macro PARAM_ADD_ACC_SAT_EN: mode-1 overflow saturates instead of wrapping.
module param_add_acc #(
  parameter int WIDTH = 3,
  parameter int ACC_W = 8,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  param_add_acc_if.slave bus
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t state_q, state_d;

  logic             accept;
  logic [WIDTH:0]   s;
  logic [ACC_W:0]   nxt;
  logic [ACC_W-1:0] add_res;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic [ACC_W-1:0] z_q, z_d;
  logic             ovf_q, ovf_d, ovf_base;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;

  assign bus.in_ready = (state_q == IDLE) | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;

  assign s = (WIDTH+1)'(bus.x) + (WIDTH+1)'(bus.y);

  // clr is applied before a same-cycle transaction
  assign acc_base = bus.clr ? '0 : acc_q;
  assign ovf_base = bus.clr ? 1'b0 : ovf_q;
  assign cnt_base = bus.clr ? '0 : cnt_q;

  assign nxt = (ACC_W+1)'(acc_base) + (ACC_W+1)'(s);

`ifdef PARAM_ADD_ACC_SAT_EN
  assign add_res = nxt[ACC_W] ? '1 : nxt[ACC_W-1:0];
`else
  assign add_res = nxt[ACC_W-1:0];
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = FULL;
      FULL: if (bus.out_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d = acc_base;
    ovf_d = ovf_base;
    cnt_d = cnt_base;
    z_d   = z_q;
    if (accept) begin
      cnt_d = cnt_base + CNT_W'(1);
      if (bus.mode) begin
        acc_d = add_res;
        z_d   = add_res;
        ovf_d = ovf_base | nxt[ACC_W];
      end else begin
        z_d = ACC_W'(s);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      z_q     <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      z_q     <= z_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_valid = (state_q == FULL);
  assign bus.z         = z_q;
  assign bus.ovf       = ovf_q;
  assign bus.txn_cnt   = cnt_q;

endmodule

// File: tb/tb_param_add_acc.sv
// Directed self-checking bench for param_add_acc (WIDTH=3, ACC_W=8).
// Expected values depend on whether PARAM_ADD_ACC_SAT_EN is defined.
module tb_param_add_acc;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  param_add_acc_if #(.WIDTH(3), .ACC_W(8), .CNT_W(8)) bus ();

  param_add_acc #(.WIDTH(3), .ACC_W(8), .CNT_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic m, input logic c,
                       input logic [2:0] a, input logic [2:0] b);
    bus.in_valid = v;
    bus.mode     = m;
    bus.clr      = c;
    bus.x        = a;
    bus.y        = b;
  endtask

  task automatic clear_all();
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    step();
    bus.clr = 1'b0;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 3'd0);
    bus.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.z !== 8'd0 || bus.ovf !== 1'b0 ||
        bus.txn_cnt !== 8'd0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset: ov=%b z=%0d ovf=%b cnt=%0d ir=%b want 0 0 0 0 1",
               bus.out_valid, bus.z, bus.ovf, bus.txn_cnt, bus.in_ready);
    end
  endtask

  task automatic test_sum();
    logic [2:0] xs [4] = '{3'd5, 3'd6, 3'd7, 3'd4};
    logic [7:0] zs [4] = '{8'd10, 8'd12, 8'd14, 8'd8};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 1'b0, xs[i], xs[i]);
      step();
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.z !== zs[i] ||
          bus.txn_cnt !== 8'(i + 1)) begin
        n_fail++;
        $display("FAIL sum[%0d]: ov=%b z=%0d cnt=%0d want 1 %0d %0d",
                 i, bus.out_valid, bus.z, bus.txn_cnt, zs[i], i + 1);
      end
    end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    step();
    n_run++;
    if (bus.z !== 8'd0 || bus.txn_cnt !== 8'd5) begin
      n_fail++;
      $display("FAIL sum_acc_untouched: z=%0d cnt=%0d want 0 5",
               bus.z, bus.txn_cnt);
    end
    bus.in_valid = 1'b0;
    step();
    n_run++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL sum_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_accumulate();
    logic [7:0] exp_z;
    clear_all();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd7, 3'd7);
      step();
      if (i == 17) begin
        n_run++;
        if (bus.z !== 8'd252 || bus.ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL acc18: z=%0d ovf=%b want 252 0", bus.z, bus.ovf);
        end
      end
    end
`ifdef PARAM_ADD_ACC_SAT_EN
    exp_z = 8'd255;
`else
    exp_z = 8'd10;
`endif
    n_run++;
    if (bus.z !== exp_z || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL acc19: z=%0d ovf=%b want %0d 1", bus.z, bus.ovf, exp_z);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd1, 3'd2);
    step();
`ifdef PARAM_ADD_ACC_SAT_EN
    exp_z = 8'd255;
`else
    exp_z = 8'd13;
`endif
    n_run++;
    if (bus.z !== exp_z || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL acc_after: z=%0d ovf=%b want %0d 1", bus.z, bus.ovf, exp_z);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    clear_all();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'd6, 3'd3);
    step();
    drive(1'b1, 1'b0, 1'b0, 3'd6, 3'd7);
    for (int i = 0; i < 5; i++) begin
      n_run++;
      if (bus.out_valid !== 1'b1 || bus.z !== 8'd9 || bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall[%0d]: ov=%b z=%0d ir=%b want 1 9 0",
                 i, bus.out_valid, bus.z, bus.in_ready);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    n_run++;
    if (bus.in_ready !== 1'b1 || bus.z !== 8'd9) begin
      n_fail++;
      $display("FAIL release: ir=%b z=%0d want 1 9", bus.in_ready, bus.z);
    end
    step();
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.z !== 8'd13 || bus.txn_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL reload: ov=%b z=%0d cnt=%0d want 1 13 2",
               bus.out_valid, bus.z, bus.txn_cnt);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_clr_simul();
    logic [7:0] exp_z;
    clear_all();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      drive(1'b1, 1'b1, 1'b0, 3'd7, 3'd7);
      step();
    end
    drive(1'b1, 1'b1, 1'b0, 3'd5, 3'd5);
    step();
`ifdef PARAM_ADD_ACC_SAT_EN
    exp_z = 8'd255;
`else
    exp_z = 8'd20;
`endif
    n_run++;
    if (bus.z !== exp_z || bus.ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_clr: z=%0d ovf=%b want %0d 1", bus.z, bus.ovf, exp_z);
    end
    drive(1'b1, 1'b1, 1'b1, 3'd3, 3'd4);
    step();
    n_run++;
    if (bus.z !== 8'd7 || bus.ovf !== 1'b0 || bus.txn_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL clr_accept: z=%0d ovf=%b cnt=%0d want 7 0 1",
               bus.z, bus.ovf, bus.txn_cnt);
    end
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    step();
    n_run++;
    if (bus.z !== 8'd7 || bus.txn_cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL clr_acc_kept: z=%0d cnt=%0d want 7 2", bus.z, bus.txn_cnt);
    end
    bus.out_ready = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 3'd0, 3'd0);
    step();
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.z !== 8'd7 || bus.txn_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL clr_alone: ov=%b z=%0d cnt=%0d want 1 7 0",
               bus.out_valid, bus.z, bus.txn_cnt);
    end
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b1, 1'b0, 3'd0, 3'd0);
    step();
    n_run++;
    if (bus.z !== 8'd0 || bus.ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_alone_acc: z=%0d ovf=%b want 0 0", bus.z, bus.ovf);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_cnt_wrap();
    clear_all();
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd1);
    for (int i = 0; i < 256; i++) step();
    n_run++;
    if (bus.txn_cnt !== 8'd0 || bus.z !== 8'd2) begin
      n_fail++;
      $display("FAIL cnt_wrap: cnt=%0d z=%0d want 0 2", bus.txn_cnt, bus.z);
    end
    step();
    n_run++;
    if (bus.txn_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL cnt_after_wrap: cnt=%0d want 1", bus.txn_cnt);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    clear_all();
    bus.out_ready = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 3'd7, 3'd7);
    step();
    bus.in_valid = 1'b0;
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.z !== 8'd14) begin
      n_fail++;
      $display("FAIL pre_rst: ov=%b z=%0d want 1 14", bus.out_valid, bus.z);
    end
    #2;
    rst = 1'b1;
    #1;
    n_run++;
    if (bus.out_valid !== 1'b0 || bus.z !== 8'd0 || bus.txn_cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL async_rst: ov=%b z=%0d cnt=%0d want 0 0 0",
               bus.out_valid, bus.z, bus.txn_cnt);
    end
    step();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 3'd1, 3'd2);
    step();
    n_run++;
    if (bus.out_valid !== 1'b1 || bus.z !== 8'd3 || bus.txn_cnt !== 8'd1) begin
      n_fail++;
      $display("FAIL post_rst: ov=%b z=%0d cnt=%0d want 1 3 1",
               bus.out_valid, bus.z, bus.txn_cnt);
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_sum();
    test_accumulate();
    test_backpressure();
    test_clr_simul();
    test_cnt_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
